// File: rtl/lcd_hd44780_pkg.sv
// -----------------------------------------------------------------------------
// lcd_hd44780_pkg
// Shared definitions for the HD44780-compatible responder:
//   - state_t      : bus FSM state encoding
//   - CMD_*        : command opcode masks (highest set bit selects the command)
//   - LINE*_BASE/END : DDRAM line address bounds as seen by the address counter
//   - BLANK_CHAR   : fill value written by Clear Display
//   - ac_next / ac_legal / ac_to_idx / shift_step : address and shift helpers
// -----------------------------------------------------------------------------
package lcd_hd44780_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_E_HIGH,
    ST_DECODE,
    ST_EXEC
  } state_t;

  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
  localparam logic [7:0] CMD_SET_CGRAM = 8'h40;
  localparam logic [7:0] CMD_FUNC_SET  = 8'h20;
  localparam logic [7:0] CMD_SHIFT     = 8'h10;
  localparam logic [7:0] CMD_DISP_CTRL = 8'h08;
  localparam logic [7:0] CMD_ENTRY     = 8'h04;
  localparam logic [7:0] CMD_HOME      = 8'h02;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;

  localparam logic [6:0] LINE0_BASE = 7'h00;
  localparam logic [6:0] LINE0_END  = 7'h27;
  localparam logic [6:0] LINE1_BASE = 7'h40;
  localparam logic [6:0] LINE1_END  = 7'h67;

  localparam logic [7:0] BLANK_CHAR  = 8'h20;
  localparam int         DDRAM_DEPTH = 80;
  localparam logic [5:0] SHIFT_MAX   = 6'd39;

  // Address counter step; the two lines form one 80-cell ring.
  function automatic logic [6:0] ac_next(input logic [6:0] ac, input logic inc);
    if (inc) begin
      if (ac == LINE0_END)      return LINE1_BASE;
      else if (ac == LINE1_END) return LINE0_BASE;
      else                      return ac + 7'd1;
    end else begin
      if (ac == LINE0_BASE)      return LINE1_END;
      else if (ac == LINE1_BASE) return LINE0_END;
      else                       return ac - 7'd1;
    end
  endfunction

  function automatic logic ac_legal(input logic [6:0] a);
    return (a <= LINE0_END) || ((a >= LINE1_BASE) && (a <= LINE1_END));
  endfunction

  // line*40 + col; illegal addresses fold onto cell 0.
  function automatic logic [6:0] ac_to_idx(input logic [6:0] ac);
    if (!ac_legal(ac)) return 7'd0;
    return ac[6] ? (7'd40 + {1'b0, ac[5:0]}) : {1'b0, ac[5:0]};
  endfunction

  function automatic logic [5:0] shift_step(input logic [5:0] s, input logic up);
    if (up) return (s == SHIFT_MAX) ? 6'd0 : s + 6'd1;
    else    return (s == 6'd0) ? SHIFT_MAX : s - 6'd1;
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// -----------------------------------------------------------------------------
// lcd_ddram
// 80x8 display data RAM addressed in address-counter format (0x00-0x27,
// 0x40-0x67). One write port, one combinational bus read port, one
// registered debug peek port.
//   clk, rst   : clock, async active-high reset (peek register only)
//   we/waddr/wdata : write port
//   raddr/rdata    : bus read port (combinational)
//   peek_addr/peek_data : debug read, 1-cycle latency
// -----------------------------------------------------------------------------
module lcd_ddram
  import lcd_hd44780_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [6:0] waddr,
  input  logic [7:0] wdata,
  input  logic [6:0] raddr,
  output logic [7:0] rdata,
  input  logic [6:0] peek_addr,
  output logic [7:0] peek_data
);

  logic [7:0] mem [DDRAM_DEPTH];

  // NOTE: the array has no reset; contents are defined by Clear Display, and
  // leaving it unreset lets it map onto RAM rather than flops.
  always_ff @(posedge clk) begin
    if (we) mem[ac_to_idx(waddr)] <= wdata;
  end

  assign rdata = mem[ac_to_idx(raddr)];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) peek_data <= '0;
    else     peek_data <= mem[ac_to_idx(peek_addr)];
  end

endmodule

// File: rtl/lcd_hd44780_responder.sv
// -----------------------------------------------------------------------------
// lcd_hd44780_responder
// Display-side HD44780-compatible responder for the 8-bit parallel bus.
// Latches rs/rw/data after a synchronized E rise, executes on E fall, models
// busy timing, and answers status and DDRAM reads while E is high.
// Ports:
//   clk, rst                  : clock, async active-high reset
//   lcd_data/lcd_rs/lcd_rw/lcd_e : bus from the driver
//   lcd_dout/lcd_doe          : read-back data and its valid
//   busy, addr_cnt            : BF and AC
//   disp_on/cursor_on/blink_on, disp_shift : display state
//   peek_addr/peek_char       : debug DDRAM read, 1-cycle latency
//   cmd_strobe                : pulse per accepted write
//   err_busy_wr               : sticky, write arrived while busy
// Optional (macro LCD_TIMING_CHECK_EN): err_timing, sticky, short E-high
// width or bus change while E is high.
// -----------------------------------------------------------------------------
module lcd_hd44780_responder
  import lcd_hd44780_pkg::*;
#(
  parameter int CMD_CYC   = 1850,
  parameter int CLR_CYC   = 76000,
  parameter int E_MIN_CYC = 12
) (
  input  logic       clk,
  input  logic       rst,
`ifdef LCD_TIMING_CHECK_EN
  output logic       err_timing,
`endif
  input  logic [7:0] lcd_data,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_e,
  output logic [7:0] lcd_dout,
  output logic       lcd_doe,
  output logic       busy,
  output logic [6:0] addr_cnt,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic [5:0] disp_shift,
  input  logic [6:0] peek_addr,
  output logic [7:0] peek_char,
  output logic       cmd_strobe,
  output logic       err_busy_wr
);

  localparam int CNT_MAX = (CLR_CYC > CMD_CYC) ? CLR_CYC : CMD_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t           state;
  logic [2:0]       e_sync;
  logic             e_rise, e_fall;
  logic             rs_q, rw_q;
  logic [7:0]       data_q;
  logic [CNT_W-1:0] busy_cnt;
  logic             inc_dec, ent_shift;
  logic             clr_active;
  logic [6:0]       clr_addr;
  logic             dat_wr, clr_cmd;
  logic             ram_we;
  logic [6:0]       ram_waddr;
  logic [7:0]       ram_wdata, bus_rdata;

  assign e_rise  = e_sync[1] & ~e_sync[2];
  assign e_fall  = ~e_sync[1] & e_sync[2];
  assign dat_wr  = (state == ST_DECODE) && !rw_q && rs_q && !busy;
  assign clr_cmd = !rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);

  // NOTE: combinational outputs get a default first so no path infers a latch.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = addr_cnt;
    ram_wdata = data_q;
    if (clr_active) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr;
      ram_wdata = BLANK_CHAR;
    end else if (dat_wr) begin
      ram_we = 1'b1;
    end
  end

  lcd_ddram u_ddram (
    .clk       (clk),
    .rst       (rst),
    .we        (ram_we),
    .waddr     (ram_waddr),
    .wdata     (ram_wdata),
    .raddr     (addr_cnt),
    .rdata     (bus_rdata),
    .peek_addr (peek_addr),
    .peek_data (peek_char)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      e_sync      <= '0;
      rs_q        <= 1'b0;
      rw_q        <= 1'b0;
      data_q      <= '0;
      busy        <= 1'b0;
      busy_cnt    <= '0;
      addr_cnt    <= '0;
      inc_dec     <= 1'b1;
      ent_shift   <= 1'b0;
      disp_on     <= 1'b0;
      cursor_on   <= 1'b0;
      blink_on    <= 1'b0;
      disp_shift  <= '0;
      clr_active  <= 1'b0;
      clr_addr    <= '0;
      lcd_dout    <= '0;
      lcd_doe     <= 1'b0;
      cmd_strobe  <= 1'b0;
      err_busy_wr <= 1'b0;
    end else begin
      e_sync     <= {e_sync[1:0], lcd_e};
      cmd_strobe <= 1'b0;

      // Busy countdown runs independently of the bus FSM.
      if (busy) begin
        if (busy_cnt == '0) busy <= 1'b0;
        else                busy_cnt <= busy_cnt - 1'b1;
      end

      // Clear fill walks the whole AC ring, one cell per cycle.
      if (clr_active) begin
        if (clr_addr == LINE1_END) begin
          clr_active <= 1'b0;
          addr_cnt   <= LINE0_BASE;
          disp_shift <= '0;
          inc_dec    <= 1'b1;
        end else begin
          clr_addr <= ac_next(clr_addr, 1'b1);
        end
      end

      case (state)
        ST_IDLE, ST_EXEC: begin
          if (e_rise) begin
            state    <= ST_E_HIGH;
            rs_q     <= lcd_rs;
            rw_q     <= lcd_rw;
            data_q   <= lcd_data;
            lcd_doe  <= lcd_rw;
            lcd_dout <= lcd_rs ? bus_rdata : {busy, addr_cnt};
          end else if (state == ST_EXEC && !busy) begin
            state <= ST_IDLE;
          end
        end

        ST_E_HIGH: begin
          if (e_fall) begin
            lcd_doe <= 1'b0;
            if (rw_q) begin
              state <= ST_IDLE;
              if (rs_q && !busy) addr_cnt <= ac_next(addr_cnt, inc_dec);
            end else begin
              state <= ST_DECODE;
            end
          end else begin
            lcd_doe  <= rw_q;
            lcd_dout <= rs_q ? bus_rdata : {busy, addr_cnt};
          end
        end

        ST_DECODE: begin
          if (busy) begin
            err_busy_wr <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            cmd_strobe <= 1'b1;
            busy       <= 1'b1;
            busy_cnt   <= clr_cmd ? CNT_W'(CLR_CYC - 1) : CNT_W'(CMD_CYC - 1);
            state      <= ST_EXEC;
            if (rs_q) begin
              addr_cnt <= ac_next(addr_cnt, inc_dec);
              if (ent_shift) disp_shift <= shift_step(disp_shift, inc_dec);
            end else if ((data_q & CMD_SET_DDRAM) != '0) begin
              addr_cnt <= ac_legal(data_q[6:0]) ? data_q[6:0] : LINE0_BASE;
            end else if ((data_q & (CMD_SET_CGRAM | CMD_FUNC_SET)) != '0) begin
              // CGRAM address and function set are accepted without effect.
            end else if ((data_q & CMD_SHIFT) != '0) begin
              if (data_q[3]) disp_shift <= shift_step(disp_shift, data_q[2]);
              else           addr_cnt   <= ac_next(addr_cnt, data_q[2]);
            end else if ((data_q & CMD_DISP_CTRL) != '0) begin
              disp_on   <= data_q[2];
              cursor_on <= data_q[1];
              blink_on  <= data_q[0];
            end else if ((data_q & CMD_ENTRY) != '0) begin
              inc_dec   <= data_q[1];
              ent_shift <= data_q[0];
            end else if ((data_q & CMD_HOME) != '0) begin
              addr_cnt   <= LINE0_BASE;
              disp_shift <= '0;
            end else if ((data_q & CMD_CLEAR) != '0) begin
              clr_active <= 1'b1;
              clr_addr   <= LINE0_BASE;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef LCD_TIMING_CHECK_EN
  logic [15:0] e_width;

  // Width is counted in synchronized cycles; bus changes are compared against
  // the values latched at the E rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_timing <= 1'b0;
      e_width    <= '0;
    end else begin
      if (e_rise && (state == ST_IDLE || state == ST_EXEC)) begin
        e_width <= 16'd1;
      end else if (state == ST_E_HIGH && e_width != 16'hFFFF) begin
        e_width <= e_width + 16'd1;
      end
      if (state == ST_E_HIGH) begin
        if (e_fall && e_width < 16'(E_MIN_CYC)) err_timing <= 1'b1;
        if ({lcd_rs, lcd_rw, lcd_data} != {rs_q, rw_q, data_q}) err_timing <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// -----------------------------------------------------------------------------
// tb_lcd_hd44780_responder
// Directed bench for lcd_hd44780_responder with short busy parameters.
// Expected values are pushed to a scoreboard queue as stimulus is issued and
// popped when the corresponding DUT output is sampled.
// -----------------------------------------------------------------------------
module tb_lcd_hd44780_responder;

  localparam int CMD_CYC   = 200;
  localparam int CLR_CYC   = 400;
  localparam int E_MIN_CYC = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_dout;
  logic       lcd_doe, busy;
  logic [6:0] addr_cnt;
  logic       disp_on, cursor_on, blink_on;
  logic [5:0] disp_shift;
  logic [6:0] peek_addr;
  logic [7:0] peek_char;
  logic       cmd_strobe, err_busy_wr;
`ifdef LCD_TIMING_CHECK_EN
  logic       err_timing;
`endif

  always #5 clk = ~clk;

  lcd_hd44780_responder #(
    .CMD_CYC   (CMD_CYC),
    .CLR_CYC   (CLR_CYC),
    .E_MIN_CYC (E_MIN_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef LCD_TIMING_CHECK_EN
    .err_timing  (err_timing),
`endif
    .lcd_data    (lcd_data),
    .lcd_rs      (lcd_rs),
    .lcd_rw      (lcd_rw),
    .lcd_e       (lcd_e),
    .lcd_dout    (lcd_dout),
    .lcd_doe     (lcd_doe),
    .busy        (busy),
    .addr_cnt    (addr_cnt),
    .disp_on     (disp_on),
    .cursor_on   (cursor_on),
    .blink_on    (blink_on),
    .disp_shift  (disp_shift),
    .peek_addr   (peek_addr),
    .peek_char   (peek_char),
    .cmd_strobe  (cmd_strobe),
    .err_busy_wr (err_busy_wr)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  int          strobe_cnt = 0;
  int          exp_strobes = 0;
  int          busy_run = 0;
  int          last_busy_len = 0;

  // Counts accepted-write pulses and measures the length of each busy period.
  always @(posedge clk) begin
    if (rst) begin
      busy_run = 0;
    end else begin
      if (cmd_strobe === 1'b1) strobe_cnt++;
      if (busy === 1'b1) busy_run++;
      else if (busy_run != 0) begin
        last_busy_len = busy_run;
        busy_run = 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $error("FAIL sb_empty: observed %0h with no expected value queued", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        n_bad++;
        $error("FAIL %s: observed %0h expected %0h", t, obs, e);
      end
    end
  endtask

  task automatic bus_write(input logic rs, input logic [7:0] d, input bit accept,
                           input int ew = 14);
    lcd_rs = rs; lcd_rw = 1'b0; lcd_data = d;
    step(2);
    lcd_e = 1'b1;
    step(ew);
    lcd_e = 1'b0;
    step(6);
    if (accept) exp_strobes++;
  endtask

  task automatic bus_read(input logic rs, output logic [7:0] v, output logic doe);
    lcd_rs = rs; lcd_rw = 1'b1;
    step(2);
    lcd_e = 1'b1;
    step(10);
    v   = lcd_dout;
    doe = lcd_doe;
    lcd_e = 1'b0;
    step(6);
    lcd_rw = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      step(1);
      n++;
    end
    if (busy !== 1'b0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL wait_idle: busy=%b after %0d cycles, expected 0", busy, n);
    end
    step(2);
  endtask

  task automatic peek(input logic [6:0] a, output logic [7:0] v);
    peek_addr = a;
    step(2);
    v = peek_char;
  endtask

  initial begin
    logic [7:0] v;
    logic       doe;

    rst = 1'b1; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0;
    lcd_data = 8'h00; peek_addr = 7'h00;
    step(5);
    rst = 1'b0;
    step(2);

    // Reset state
    push_exp("rst_busy", 0);   check(busy);
    push_exp("rst_ac", 0);     check(addr_cnt);
    push_exp("rst_shift", 0);  check(disp_shift);
    push_exp("rst_flags", 0);
    check({err_busy_wr, cmd_strobe, lcd_doe, disp_on, cursor_on, blink_on});

    // Clear display: long busy, every line end blanked
    bus_write(1'b0, 8'h01, 1);
    push_exp("clr_busy_len", CLR_CYC);
    wait_idle();
    check(last_busy_len);
    push_exp("clr_0x00", 8'h20); peek(7'h00, v); check(v);
    push_exp("clr_0x27", 8'h20); peek(7'h27, v); check(v);
    push_exp("clr_0x40", 8'h20); peek(7'h40, v); check(v);
    push_exp("clr_0x67", 8'h20); peek(7'h67, v); check(v);
    push_exp("clr_ac", 7'h00);   check(addr_cnt);

    // Entry mode increment, two data writes
    bus_write(1'b0, 8'h06, 1); wait_idle();
    bus_write(1'b0, 8'h80, 1); wait_idle();
    bus_write(1'b1, 8'h41, 1); wait_idle();
    bus_write(1'b1, 8'h42, 1); wait_idle();
    push_exp("wr_0x00", 8'h41); peek(7'h00, v); check(v);
    push_exp("wr_0x01", 8'h42); peek(7'h01, v); check(v);
    push_exp("wr_ac", 7'h02);   check(addr_cnt);

    // Line-end wrap 0x27 -> 0x40, then decrement wrap 0x00 -> 0x67
    bus_write(1'b0, 8'hA7, 1); wait_idle();
    push_exp("set_ac_27", 7'h27); check(addr_cnt);
    bus_write(1'b1, 8'h5A, 1); wait_idle();
    push_exp("wr_0x27", 8'h5A); peek(7'h27, v); check(v);
    push_exp("wrap_ac_40", 7'h40); check(addr_cnt);
    bus_write(1'b0, 8'h04, 1); wait_idle();
    bus_write(1'b0, 8'h80, 1); wait_idle();
    bus_write(1'b1, 8'h31, 1); wait_idle();
    push_exp("dec_wrap_ac_67", 7'h67); check(addr_cnt);
    push_exp("wr_dec_0x00", 8'h31); peek(7'h00, v); check(v);

    // Display control, then status read and a dropped write while busy
    bus_write(1'b0, 8'h0E, 1);
    push_exp("status_dout", 8'hE7);
    push_exp("status_doe", 1);
    bus_read(1'b0, v, doe);
    check(v);
    check(doe);
    push_exp("doe_after_read", 0); check(lcd_doe);
    bus_write(1'b0, 8'h80, 0);
    push_exp("err_busy_wr", 1);   check(err_busy_wr);
    push_exp("dropped_ac", 7'h67); check(addr_cnt);
    wait_idle();
    push_exp("dcb", 3'b110); check({disp_on, cursor_on, blink_on});

    // Entry shift on, three data writes shift display; then shift left, home
    bus_write(1'b0, 8'h07, 1); wait_idle();
    for (int i = 0; i < 3; i++) begin
      bus_write(1'b1, 8'h20, 1);
      wait_idle();
    end
    push_exp("shift_3", 3);   check(disp_shift);
    push_exp("ac_wrap_02", 7'h02); check(addr_cnt);
    bus_write(1'b0, 8'h18, 1); wait_idle();
    push_exp("shift_2", 2);   check(disp_shift);
    bus_write(1'b0, 8'h02, 1); wait_idle();
    push_exp("home_ac", 0);    check(addr_cnt);
    push_exp("home_shift", 0); check(disp_shift);

    // Data read steps AC across the line boundary; cursor move left wraps back
    bus_write(1'b0, 8'hA7, 1); wait_idle();
    push_exp("rd_data", 8'h5A);
    bus_read(1'b1, v, doe);
    check(v);
    push_exp("rd_ac_40", 7'h40); check(addr_cnt);
    bus_write(1'b0, 8'h10, 1); wait_idle();
    push_exp("cur_left_27", 7'h27); check(addr_cnt);

`ifdef LCD_TIMING_CHECK_EN
    push_exp("timing_clean", 0); check(err_timing);
    bus_write(1'b0, 8'h08, 1, 4); wait_idle();
    push_exp("timing_short_e", 1); check(err_timing);
    push_exp("timing_exec", 0); check(disp_on);
`endif

    push_exp("strobe_count", exp_strobes); check(strobe_cnt);

    // Reset in the middle of a Clear aborts it at once
    bus_write(1'b0, 8'h01, 1);
    step(20);
    push_exp("clr_running", 1); check(busy);
    rst = 1'b1;
    #1;
    push_exp("rst_mid_clr_busy", 0); check(busy);
    push_exp("rst_mid_clr_ac", 0);   check(addr_cnt);
    step(3);
    rst = 1'b0;
    step(3);
    push_exp("post_rst_busy", 0); check(busy);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
